// File: rtl/hack_cpu.sv
// rtl/hack_cpu.sv - multi-cycle Hack CPU core with ROM fetch, ready-handshake data port and Hack ALU
//
// Optional feature macro: HACK_CPU_HALT_EN (jump-to-self enters a sticky HALT state).
//
// alu ports:
//   x, y            16-bit operands
//   zx,nx,zy,ny,f,no Hack ALU control bits
//   out, zr, ng     result, result==0, result<0
//
// hack_cpu ports:
//   clk, rst_n      clock, synchronous active-low reset
//   rom_addr/rom_data  instruction fetch; ROM data valid one cycle after address
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata/mem_ready  data port, request held until ready
//   pc              program counter
//   halted          high in HALT (tied low without HACK_CPU_HALT_EN)

module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    always_comb begin
        x_z   = zx ? 16'h0000 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? 16'h0000 : y;
        y_n   = ny ? ~y_z : y_z;
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        out   = no ? ~f_out : f_out;
        zr    = (out == 16'h0000);
        ng    = out[15];
    end
endmodule

module hack_cpu (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [14:0] pc,
    output logic        halted
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEMRD  = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMWR  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] m_q, m_d;
    logic [15:0] ir_q, ir_d;
    logic [14:0] pc_q, pc_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic [14:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
`ifdef HACK_CPU_HALT_EN
    // A jump-to-self that also writes M finishes its MEMWR before halting.
    logic        halt_pend_q, halt_pend_d;
`endif

    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        jump;
    logic [14:0] pc_inc;

    assign alu_y  = ir_q[12] ? m_q : a_q;
    assign pc_inc = pc_q + 15'd1;
    assign jump   = ir_q[15] & ((ir_q[2] & alu_ng) |
                                (ir_q[1] & alu_zr) |
                                (ir_q[0] & ~alu_ng & ~alu_zr));

    alu u_alu (
        .x   (d_q),
        .y   (alu_y),
        .zx  (ir_q[11]),
        .nx  (ir_q[10]),
        .zy  (ir_q[9]),
        .ny  (ir_q[8]),
        .f   (ir_q[7]),
        .no  (ir_q[6]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        d_d         = d_q;
        m_d         = m_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef HACK_CPU_HALT_EN
        halt_pend_d = halt_pend_q;
`endif
        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d = rom_data;
                if (rom_data[15] && rom_data[12]) begin
                    state_d    = S_MEMRD;
                    mem_re_d   = 1'b1;
                    mem_addr_d = a_q[14:0];
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    m_d      = mem_rdata;
                    mem_re_d = 1'b0;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!ir_q[15]) begin
                    a_d     = {1'b0, ir_q[14:0]};
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else begin
                    if (ir_q[5]) a_d = alu_out;
                    if (ir_q[4]) d_d = alu_out;
                    // Jump target and M address use A as it was before this instruction.
                    pc_d = jump ? a_q[14:0] : pc_inc;
                    if (ir_q[3]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = a_q[14:0];
                        mem_wdata_d = alu_out;
                        state_d     = S_MEMWR;
                    end else begin
                        state_d = S_FETCH;
                    end
`ifdef HACK_CPU_HALT_EN
                    if (jump && (a_q[14:0] == pc_q)) begin
                        if (ir_q[3]) halt_pend_d = 1'b1;
                        else         state_d     = S_HALT;
                    end
`endif
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    mem_we_d = 1'b0;
                    state_d  = S_FETCH;
`ifdef HACK_CPU_HALT_EN
                    if (halt_pend_q) state_d = S_HALT;
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            a_q         <= 16'h0000;
            d_q         <= 16'h0000;
            m_q         <= 16'h0000;
            ir_q        <= 16'h0000;
            pc_q        <= 15'h0000;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 15'h0000;
            mem_wdata_q <= 16'h0000;
`ifdef HACK_CPU_HALT_EN
            halt_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            d_q         <= d_d;
            m_q         <= m_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef HACK_CPU_HALT_EN
            halt_pend_q <= halt_pend_d;
`endif
        end
    end

    // pc only moves at the EXEC edge, so it is already stable as the FETCH address.
    assign rom_addr  = pc_q;
    assign pc        = pc_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
`ifdef HACK_CPU_HALT_EN
    assign halted    = (state_q == S_HALT);
`else
    assign halted    = 1'b0;
`endif
endmodule
